// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan_nx1 block and its benches.
package mux_scan_pkg;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Lowest bit of channel k inside the packed lane bus.
  function automatic int unsigned lane_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/mux_nx1.sv
// Combinational N:1 selector of W-bit lanes; an unmatched select yields zero.
module mux_nx1
  import mux_scan_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 1,
  parameter int unsigned SEL_W = sel_width(N)
) (
  input  logic [N*W-1:0]   i,
  input  logic [SEL_W-1:0] s,
  output logic [W-1:0]     y
);

  always_comb begin
    y = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (s == SEL_W'(k)) begin
        y = i[lane_lo(k, W) +: W];
      end
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// Registered N:1 mux with valid/ready output and a start-triggered channel scan.
// Optional feature: define SCAN_MASK_EN to add a ch_mask port restricting the scan.
module mux_scan_nx1
  import mux_scan_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 1,
  parameter int unsigned SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   i,
  input  logic [SEL_W-1:0] s,
  input  logic             mode,
  input  logic             start,
`ifdef SCAN_MASK_EN
  input  logic [N-1:0]     ch_mask,
`endif
  input  logic             out_ready,
  output logic [W-1:0]     y,
  output logic [SEL_W-1:0] y_sel,
  output logic             y_valid,
  output logic             busy,
  output logic             done
);

  state_e           state;
  logic             start_pend;
  logic             load_ok;
  logic             scan_go;
  logic             first_found;
  logic [SEL_W-1:0] first_idx;
  logic             nxt_found;
  logic [SEL_W-1:0] nxt_idx;
  logic [SEL_W-1:0] mux_sel;
  logic [W-1:0]     mux_y;

  assign load_ok = !y_valid || out_ready;
  // A start that arrives while a manual sample is still stalled waits for it to drain.
  assign scan_go = mode && (start || start_pend);
  assign busy    = (state == StScan);

`ifdef SCAN_MASK_EN
  logic [N-1:0] mask_q;

  // Descending loop so the lowest qualifying channel wins.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    nxt_found   = 1'b0;
    nxt_idx     = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (ch_mask[k]) begin
        first_found = 1'b1;
        first_idx   = SEL_W'(k);
      end
      if (mask_q[k] && (k > int'(y_sel))) begin
        nxt_found = 1'b1;
        nxt_idx   = SEL_W'(k);
      end
    end
  end
`else
  assign first_found = 1'b1;
  assign first_idx   = '0;
  assign nxt_found   = (y_sel != SEL_W'(N - 1));
  assign nxt_idx     = y_sel + SEL_W'(1);
`endif

  always_comb begin
    if (state == StScan) begin
      mux_sel = nxt_idx;
    end else if (scan_go) begin
      mux_sel = first_idx;
    end else begin
      mux_sel = s;
    end
  end

  mux_nx1 #(
    .N     (N),
    .W     (W),
    .SEL_W (SEL_W)
  ) u_mux (
    .i (i),
    .s (mux_sel),
    .y (mux_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= StIdle;
      start_pend <= 1'b0;
      y          <= '0;
      y_sel      <= '0;
      y_valid    <= 1'b0;
      done       <= 1'b0;
`ifdef SCAN_MASK_EN
      mask_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (scan_go) begin
            if (!first_found) begin
              start_pend <= 1'b0;
              done       <= 1'b1;
              if (load_ok) begin
                y_valid <= 1'b0;
              end
            end else if (load_ok) begin
              state      <= StScan;
              start_pend <= 1'b0;
              y          <= mux_y;
              y_sel      <= first_idx;
              y_valid    <= 1'b1;
`ifdef SCAN_MASK_EN
              mask_q     <= ch_mask;
`endif
            end else begin
              start_pend <= 1'b1;
            end
          end else if (!mode) begin
            start_pend <= 1'b0;
            if (load_ok) begin
              y       <= mux_y;
              y_sel   <= s;
              y_valid <= 1'b1;
            end
          end else if (load_ok) begin
            y_valid <= 1'b0;
          end
        end
        StScan: begin
          if (out_ready) begin
            if (nxt_found) begin
              y     <= mux_y;
              y_sel <= nxt_idx;
            end else begin
              state   <= StIdle;
              y_valid <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Directed self-checking bench for mux_scan_nx1 (N=8, W=4); mask checks need SCAN_MASK_EN.
module tb_mux_scan_nx1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i;
  logic [2:0]  s;
  logic        mode;
  logic        start;
  logic        out_ready;
  logic [7:0]  ch_mask;
  logic [3:0]  y;
  logic [2:0]  y_sel;
  logic        y_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mux_scan_nx1 #(
    .N (8),
    .W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i         (i),
    .s         (s),
    .mode      (mode),
    .start     (start),
`ifdef SCAN_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .out_ready (out_ready),
    .y         (y),
    .y_sel     (y_sel),
    .y_valid   (y_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full scan with lane k = k+1; optional stall at channel stall_at and a stray start.
  task automatic scan_run(input int stall_at, input int stall_len, input int restart_at);
    int exp_sel;
    int cyc;
    int stalled;
    int extra_done;
    logic acc;
    bit restarted;
    exp_sel   = 0;
    cyc       = 0;
    stalled   = 0;
    restarted = 0;
    mode      = 1'b1;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 40 && !done) begin
      chk("scan_sel", 32'(y_sel), 32'(exp_sel));
      chk("scan_y", 32'(y), 32'(exp_sel + 1));
      chk("scan_valid_busy", {30'd0, y_valid, busy}, 32'd3);
      if (exp_sel == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
      end
      if (exp_sel == restart_at && !restarted) begin
        start     = 1'b1;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      acc = out_ready;
      tick();
      cyc++;
      if (acc) exp_sel++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("scan_done_seen", 32'(done), 32'd1);
    chk("scan_count", 32'(exp_sel), 32'd8);
    chk("scan_cycles", 32'(cyc), 32'(8 + stall_len));
    chk("done_idle", {30'd0, y_valid, busy}, 32'd0);
    extra_done = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) extra_done++;
    end
    chk("single_done", 32'(extra_done), 32'd0);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [2:0]  sel;
    logic [3:0]  exp_y;
  } man_vec_t;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    man_vec_t vecs[11];
    int done_cnt;
    for (int k = 0; k < 8; k++) begin
      vecs[k] = '{32'h7654_3210, 3'(k), 4'(k)};
    end
    vecs[8]  = '{32'h89AB_CDEF, 3'd0, 4'hF};
    vecs[9]  = '{32'h89AB_CDEF, 3'd5, 4'hA};
    vecs[10] = '{32'h89AB_CDEF, 3'd7, 4'h8};

    rst_n     = 1'b0;
    i         = '0;
    s         = '0;
    mode      = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    ch_mask   = 8'hFF;
    repeat (3) tick();
    chk("reset_outputs", {y, 1'b0, y_sel, y_valid, busy, done}, 32'd0);
    rst_n = 1'b1;

    // Manual sweep
    foreach (vecs[n]) begin
      i = vecs[n].data;
      s = vecs[n].sel;
      tick();
      chk("man_y", 32'(y), 32'(vecs[n].exp_y));
      chk("man_sel", 32'(y_sel), 32'(vecs[n].sel));
      chk("man_valid", {30'd0, y_valid, busy}, 32'd2);
    end

    // Manual hold under backpressure
    i = 32'h7654_3210;
    s = 3'd3;
    tick();
    out_ready = 1'b0;
    s = 3'd6;
    repeat (2) begin
      tick();
      chk("man_hold", {28'd0, y}, 32'd3);
      chk("man_hold_sel", 32'(y_sel), 32'd3);
    end
    out_ready = 1'b1;
    tick();
    chk("man_release", 32'(y), 32'd6);

    i = 32'h8765_4321;
    scan_run(-1, 0, -1);
    scan_run(3, 5, -1);
    scan_run(-1, 0, 2);

    // Reset mid-scan
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("midscan_sel", 32'(y_sel), 32'd3);
    rst_n = 1'b0;
    repeat (3) tick();
    chk("midrst_y", 32'(y), 32'd0);
    chk("midrst_sel", 32'(y_sel), 32'd0);
    chk("midrst_flags", {29'd0, y_valid, busy, done}, 32'd0);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done || y_valid) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    scan_run(-1, 0, -1);

    // Pending manual sample drains after switching to scan mode without start
    mode      = 1'b0;
    out_ready = 1'b0;
    s         = 3'd2;
    tick();
    chk("between_load", {27'd0, y, y_valid}, {27'd0, 4'd3, 1'b1});
    mode = 1'b1;
    tick();
    chk("between_hold", {27'd0, y, y_valid}, {27'd0, 4'd3, 1'b1});
    out_ready = 1'b1;
    tick();
    chk("between_drain", {30'd0, y_valid, busy}, 32'd0);
    tick();
    chk("between_idle", {30'd0, y_valid, busy}, 32'd0);

    // Start while a manual sample is stalled must not overwrite it
    mode      = 1'b0;
    out_ready = 1'b0;
    s         = 3'd5;
    tick();
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pend_keep_y", 32'(y), 32'd6);
    chk("pend_keep_sel", 32'(y_sel), 32'd5);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;

`ifdef SCAN_MASK_EN
    begin
      logic [2:0] mseq [4];
      int         got;
      mseq[0] = 3'd0;
      mseq[1] = 3'd2;
      mseq[2] = 3'd5;
      mseq[3] = 3'd7;
      mode    = 1'b1;
      ch_mask = 8'b1010_0101;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      ch_mask = 8'hFF;
      got     = 0;
      for (int k = 0; k < 4; k++) begin
        chk("mask_sel", 32'(y_sel), 32'(mseq[k]));
        chk("mask_y", 32'(y), 32'(mseq[k]) + 32'd1);
        tick();
      end
      chk("mask_done", {29'd0, done, busy, y_valid}, 32'd4);
      ch_mask = 8'h00;
      start   = 1'b1;
      tick();
      start = 1'b0;
      chk("mask0_done", {29'd0, done, busy, y_valid}, 32'd4);
      for (int k = 0; k < 3; k++) begin
        tick();
        if (done || busy || y_valid) got++;
      end
      chk("mask0_quiet", 32'(got), 32'd0);
      ch_mask = 8'hFF;
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_nx1.md
# mux_scan_nx1

Parametrised, registered N:1 multiplexer with a built-in channel-scan sequencer. It extends the family of small 4:1 and 8:1 selector blocks to arbitrary channel count N and data width W. The output is a registered, valid/ready-handshaked port. Two operating modes:
- **Manual:** the caller drives the select.
- **Scan:** a single start pulse sweeps every channel in ascending order, one sample per handshake.

It sits between a bank of parallel input lanes and a single serial consumer, such as a checker, UART framer or display driver.

## Interface
- `N`, default 8: number of input channels, at least 2.
- `W`, default 1: data width per channel, in bits.
- `SEL_W`, default `$clog2(N)`: select width. Derived; do not override.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: synchronous, active-low reset.
- `i`, input, N*W: channel data; channel k occupies `i[k*W +: W]`.
- `s`, input, SEL_W: manual-mode channel select.
- `mode`, input, 1: 0 = manual, 1 = scan. Sampled only in IDLE.
- `start`, input, 1: one-cycle pulse that begins a scan. Effective only when `mode`=1 and state is IDLE.
- `out_ready`, input, 1: consumer accepts `y` this cycle.
- `y`, output, W: selected data.
- `y_sel`, output, SEL_W: channel index of the data on `y`.
- `y_valid`, output, 1: `y` and `y_sel` hold a sample.
- `busy`, output, 1: scan in progress.
- `done`, output, 1: one-cycle pulse after the last scan sample is accepted.

## Operation
- **Reset** (`rst_n`=0 at a rising edge):
  - state becomes IDLE.
  - `y`=0, `y_sel`=0, `y_valid`=0, `busy`=0, `done`=0.
  - Reset mid-scan aborts the scan; no `done` is produced.
- **Output register:** loads whenever it is empty (`y_valid`=0) or being accepted (`y_valid`&&`out_ready`). Otherwise `y` and `y_sel` hold stable.
- **Manual mode** (IDLE, `mode`=0): on each load, `y`⇐`i[s*W +: W]` and `y_sel`⇐`s`, and `y_valid`⇐1.
  - Out-of-range `s` (≥N) loads `y`=0 with `y_sel`=`s`.
- **Scan mode:** states IDLE → SCAN → IDLE.
  - **IDLE**, `mode`=1, `start`=1: channel counter ⇐ first channel, state ⇐ SCAN. The output register loads that channel in the same edge.
  - **SCAN:** on each handshake, load the next channel. The counter increments by one with no wrap.
  - **Scan end:** on the handshake of the last channel, state ⇐ IDLE, `y_valid`⇐0, and `done`⇐1 for one cycle.
  - `busy` = (state == SCAN).
  - `start` and `mode` are ignored while busy.
  - A simultaneous `start` and manual request in IDLE resolves to scan when `mode`=1.
- **Manual-to-scan switch:** switching `mode` from manual to scan while a manual sample is pending is legal. That sample must be accepted, or replaced if `out_ready`=1, before the first scan sample loads.
- **Between modes:** in IDLE with `mode`=1 and no `start`, the register loads nothing. `y_valid` falls after the pending sample is accepted.

## Timing
- **Manual latency:** one cycle; `i`/`s` sampled at edge t appear on `y` after edge t.
- **Scan latency:** `start` sampled at edge t puts channel 0 on `y`, with `y_valid`=1 and `busy`=1, after edge t.
- **Scan throughput:** with `out_ready` held high, one channel per cycle. A full N-channel scan spans edges t..t+N, and `done` is high for the cycle after edge t+N.
- **Backpressure:** `out_ready`=0 stalls the sweep indefinitely with `y` and `y_sel` stable. There is no combinational path from `out_ready` to `y`.

## Configuration
- **`SCAN_MASK_EN` defined:** adds input port `ch_mask`, width N.
  - The scan visits only channels with `ch_mask[k]`=1, in ascending order. Skipped channels cost zero cycles; the next channel is found with a priority encoder.
  - `ch_mask` is sampled at `start` and held for the whole scan.
  - An all-zero mask makes `start` produce no samples, `busy` stay 0, and `done` pulse one cycle later.
  - Manual mode ignores the mask.
- **`SCAN_MASK_EN` undefined:** no `ch_mask` port; every scan visits all N channels.

## Structure
- **Package `mux_scan_pkg`:**
  - state typedef: IDLE, SCAN.
  - a `clog2`-based select-width helper.
  - the channel-slice indexing constant/function shared with benches.
- **Sub-module `mux_nx1`:** combinational, N:1, W-bit selector with out-of-range → 0. It is instantiated once. The FSM, counter, output register and mask encoder stay in the top module.

## Test plan
- **Reset:** N=8, W=4, hold `rst_n`=0 for 3 cycles mid-scan → all outputs 0, no `done`; next `start` restarts at channel 0.
- **Manual sweep:** `s`=0..7 with `i`={8'h..} lanes holding 4'h0..4'h7 each, `out_ready`=1 → `y` equals `s` one cycle later, `y_valid`=1 throughout.
- **Scan, no stall:** `mode`=1, `start` pulse, `out_ready`=1, channel k holding value k+1 → `y`=1..8 and `y_sel`=0..7 on consecutive cycles, `done` high one cycle after `y_sel`=7 is accepted, `busy` low at that point.
- **Backpressure:** drop `out_ready` for 5 cycles at `y_sel`=3 → `y` and `y_sel` frozen, no channel skipped or duplicated, `done` delayed by 5 cycles.
- **Ignored start:** pulse `start` mid-scan at `y_sel`=2 → the scan continues unchanged and exactly one `done` occurs.
- **Mask (`SCAN_MASK_EN`):** `ch_mask`=8'b1010_0101 → `y_sel` sequence 0,2,5,7 then `done`; `ch_mask`=0 → `done` one cycle after `start`, `y_valid` never asserted.
